jedro_1_csr_file: RTL

//  Parametrised machine-mode CSR file for the jedro_1 core; successor to the fixed csr_inst block.

---
 rtl/jedro_1_csr_file_pkg.sv | 32 +++
 rtl/jedro_1_csr_file_if.sv | 24 ++
 rtl/jedro_1_csr_file_counter.sv | 43 ++++
 rtl/jedro_1_csr_file.sv | 136 +++++++++++++
 4 files changed

// File: rtl/jedro_1_csr_file_pkg.sv
// Shared CSR addresses, Zicsr funct3 encodings and access-class helper
// for the jedro_1 machine-mode CSR file.
package jedro_1_csr_pkg;

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_SCRATCH0      = 12'h7C0;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    typedef enum logic [2:0] {
        CSR_RW  = 3'b001,
        CSR_RS  = 3'b010,
        CSR_RC  = 3'b011,
        CSR_RWI = 3'b101,
        CSR_RSI = 3'b110,
        CSR_RCI = 3'b111
    } csr_op_e;

    // addr[11:10]==2'b11 marks the read-only CSR space
    function automatic logic csr_is_ro(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/jedro_1_csr_file_if.sv
// Execute-stage <-> CSR file request/response bundle.
interface jedro_1_csr_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  csr_en_i;
    logic [2:0]            csr_op_i;
    logic [11:0]           csr_addr_i;
    logic [DATA_WIDTH-1:0] csr_wdata_i;
    logic                  csr_src_zero_i;
    logic                  instr_retired_i;
    logic [DATA_WIDTH-1:0] csr_rdata_o;
    logic                  csr_rvalid_o;
    logic                  csr_illegal_o;

    modport master (
        output csr_en_i, csr_op_i, csr_addr_i, csr_wdata_i, csr_src_zero_i, instr_retired_i,
        input  csr_rdata_o, csr_rvalid_o, csr_illegal_o
    );

    modport slave (
        input  csr_en_i, csr_op_i, csr_addr_i, csr_wdata_i, csr_src_zero_i, instr_retired_i,
        output csr_rdata_o, csr_rvalid_o, csr_illegal_o
    );
endinterface

// File: rtl/jedro_1_csr_file_counter.sv
// Free-running event counter with per-half CSR write; a write beats the
// same-cycle increment and leaves the unwritten half untouched.
module jedro_1_csr_counter #(
    parameter int COUNTER_WIDTH = 64,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     i_inhibit,
    input  logic                     i_inc,
    input  logic                     i_wr_lo,
    input  logic                     i_wr_hi,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    output logic [COUNTER_WIDTH-1:0] o_count
);
    logic [COUNTER_WIDTH-1:0] r_cnt;
    logic [COUNTER_WIDTH-1:0] w_next;

    if (COUNTER_WIDTH > DATA_WIDTH) begin : g_wide
        always_comb begin
            w_next = r_cnt + COUNTER_WIDTH'(i_inc & ~i_inhibit);
            if (i_wr_lo || i_wr_hi) begin
                w_next = r_cnt;
                if (i_wr_lo) w_next[DATA_WIDTH-1:0] = i_wdata;
                if (i_wr_hi) w_next[COUNTER_WIDTH-1:DATA_WIDTH] = (COUNTER_WIDTH-DATA_WIDTH)'(i_wdata);
            end
        end
    end else begin : g_narrow
        logic w_unused_hi;
        assign w_unused_hi = i_wr_hi;
        always_comb begin
            w_next = r_cnt + COUNTER_WIDTH'(i_inc & ~i_inhibit);
            if (i_wr_lo) w_next = COUNTER_WIDTH'(i_wdata);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_cnt <= '0;
        else         r_cnt <= w_next;
    end

    assign o_count = r_cnt;
endmodule

// File: rtl/jedro_1_csr_file.sv
// Machine-mode CSR file: Zicsr read-modify-write, scratch regs, counters,
// mhartid; returns the pre-write value one cycle after the request.
module jedro_1_csr_file
    import jedro_1_csr_pkg::*;
#(
    parameter int          DATA_WIDTH    = 32,
    parameter int          COUNTER_WIDTH = 64,
    parameter int          NUM_SCRATCH   = 2,
    parameter int unsigned HART_ID       = 0
) (
    input logic           clk_i,
    input logic           rstn_i,
    jedro_1_csr_if.slave  bus
);
    localparam int DW    = DATA_WIDTH;
    localparam int NS_SZ = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;
    localparam bit CNT64 = COUNTER_WIDTH > DATA_WIDTH;
    localparam logic [DW-1:0] MCI_MASK = DW'(5);

    logic [DW-1:0]            r_mscratch, r_mcountinhibit, r_rdata;
    logic                     r_rvalid, r_illegal;
    logic [DW-1:0]            r_scratch [NS_SZ];
    logic [NS_SZ-1:0]         w_scr_hit;
    logic [COUNTER_WIDTH-1:0] w_mcycle, w_minstret;
    logic [2*DW-1:0]          w_cyc_x, w_ins_x;
    logic [DW-1:0]            w_old, w_wd;
    logic                     w_op_ok, w_sel_ok, w_we, w_legal, w_wr;

    assign w_cyc_x = (2*DW)'(w_mcycle);
    assign w_ins_x = (2*DW)'(w_minstret);

    // Read mux: the old value is taken before any write or increment lands
    always_comb begin
        w_sel_ok = 1'b1;
        w_old    = '0;
        case (bus.csr_addr_i)
            CSR_MSCRATCH:              w_old = r_mscratch;
            CSR_MCOUNTINHIBIT:         w_old = r_mcountinhibit;
            CSR_MCYCLE,   CSR_CYCLE:   w_old = w_cyc_x[DW-1:0];
            CSR_MINSTRET, CSR_INSTRET: w_old = w_ins_x[DW-1:0];
            CSR_MCYCLEH,  CSR_CYCLEH: begin
                w_old    = w_cyc_x[2*DW-1:DW];
                w_sel_ok = CNT64;
            end
            CSR_MINSTRETH, CSR_INSTRETH: begin
                w_old    = w_ins_x[2*DW-1:DW];
                w_sel_ok = CNT64;
            end
            CSR_MHARTID:               w_old = DW'(HART_ID);
            default: begin
                w_sel_ok = |w_scr_hit;
                for (int k = 0; k < NUM_SCRATCH; k++)
                    if (w_scr_hit[k]) w_old = r_scratch[k];
            end
        endcase
    end

    always_comb begin
        w_op_ok = 1'b1;
        w_we    = ~bus.csr_src_zero_i;
        w_wd    = bus.csr_wdata_i;
        case (bus.csr_op_i)
            CSR_RW, CSR_RWI: w_we = 1'b1;
            CSR_RS, CSR_RSI: w_wd = w_old | bus.csr_wdata_i;
            CSR_RC, CSR_RCI: w_wd = w_old & ~bus.csr_wdata_i;
            default: begin
                w_op_ok = 1'b0;
                w_we    = 1'b0;
            end
        endcase
    end

    assign w_legal = w_op_ok & w_sel_ok & ~(w_we & csr_is_ro(bus.csr_addr_i));
    assign w_wr    = bus.csr_en_i & w_legal & w_we;

    for (genvar k = 0; k < NUM_SCRATCH; k++) begin : g_scr
        assign w_scr_hit[k] = bus.csr_addr_i == (CSR_SCRATCH0 + 12'(k));
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i)                  r_scratch[k] <= '0;
            else if (w_wr && w_scr_hit[k]) r_scratch[k] <= w_wd;
        end
    end
    if (NUM_SCRATCH == 0) begin : g_noscr
        assign w_scr_hit    = '0;
        assign r_scratch[0] = '0;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_mscratch      <= '0;
            r_mcountinhibit <= '0;
        end else if (w_wr) begin
            if (bus.csr_addr_i == CSR_MSCRATCH)      r_mscratch      <= w_wd;
            if (bus.csr_addr_i == CSR_MCOUNTINHIBIT) r_mcountinhibit <= w_wd & MCI_MASK;
        end
    end

    jedro_1_csr_counter #(.COUNTER_WIDTH(COUNTER_WIDTH), .DATA_WIDTH(DW)) u_mcycle (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .i_inhibit (r_mcountinhibit[0]),
        .i_inc     (1'b1),
        .i_wr_lo   (w_wr && bus.csr_addr_i == CSR_MCYCLE),
        .i_wr_hi   (w_wr && bus.csr_addr_i == CSR_MCYCLEH),
        .i_wdata   (w_wd),
        .o_count   (w_mcycle)
    );

    jedro_1_csr_counter #(.COUNTER_WIDTH(COUNTER_WIDTH), .DATA_WIDTH(DW)) u_minstret (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .i_inhibit (r_mcountinhibit[2]),
        .i_inc     (bus.instr_retired_i),
        .i_wr_lo   (w_wr && bus.csr_addr_i == CSR_MINSTRET),
        .i_wr_hi   (w_wr && bus.csr_addr_i == CSR_MINSTRETH),
        .i_wdata   (w_wd),
        .o_count   (w_minstret)
    );

    // rdata holds across idle cycles; illegal accesses return zero
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rvalid  <= 1'b0;
            r_illegal <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_rvalid  <= bus.csr_en_i;
            r_illegal <= bus.csr_en_i & ~w_legal;
            if (bus.csr_en_i) r_rdata <= w_legal ? w_old : '0;
        end
    end

    assign bus.csr_rdata_o   = r_rdata;
    assign bus.csr_rvalid_o  = r_rvalid;
    assign bus.csr_illegal_o = r_illegal;
endmodule
